// File: rtl/clusterv_tile_sram_bridge_pkg.sv
// Shared types and default widths for the tile SRAM Wishbone bridge.
package clusterv_tile_sram_bridge_pkg;

   localparam int DEF_ADR_WIDTH = 8;
   localparam int DEF_DAT_WIDTH = 32;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      RD_REQ = 3'd1,
      RD_CAP = 3'd2,
      WR_REQ = 3'd3,
      RESP   = 3'd4
   } bridge_state_e;

endpackage

// File: rtl/clusterv_tile_sram_wb_bridge.sv
// Wishbone classic target -> registered byte-enable SRAM initiator, one transfer at a time.
// Optional address checking with error response: CLUSTERV_TILE_SRAM_BRIDGE_ERR_EN.
module clusterv_tile_sram_wb_bridge
   import clusterv_tile_sram_bridge_pkg::*;
#(
   parameter int ADR_WIDTH = DEF_ADR_WIDTH,
   parameter int DAT_WIDTH = DEF_DAT_WIDTH
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [31:0]            wb_adr,
   input  logic [DAT_WIDTH-1:0]   wb_dat_w,
   output logic [DAT_WIDTH-1:0]   wb_dat_r,
   input  logic                   wb_cyc,
   input  logic                   wb_stb,
   input  logic                   wb_we,
   input  logic [DAT_WIDTH/8-1:0] wb_sel,
   output logic                   wb_ack,
   output logic                   wb_err,
   output logic [ADR_WIDTH-1:0]   i_addr,
   output logic [DAT_WIDTH-1:0]   i_write_data,
   input  logic [DAT_WIDTH-1:0]   i_read_data,
   output logic [DAT_WIDTH/8-1:0] i_byte_en,
   output logic                   i_read_en,
   output logic                   i_write_en
);

   localparam int BE_W = DAT_WIDTH / 8;

   bridge_state_e          state_q, state_d;
   logic [ADR_WIDTH-1:0]   addr_q, addr_d;
   logic [DAT_WIDTH-1:0]   wdata_q, wdata_d;
   logic [DAT_WIDTH-1:0]   dat_r_q, dat_r_d;
   logic [BE_W-1:0]        byte_en_q, byte_en_d;
   logic                   rd_en_q, rd_en_d;
   logic                   wr_en_q, wr_en_d;
   logic                   ack_q, ack_d;
   logic                   err_q, err_d;
   logic                   req;
   logic                   bad_adr;
   logic                   accept;

   assign req = wb_cyc & wb_stb;

`ifdef CLUSTERV_TILE_SRAM_BRIDGE_ERR_EN
   assign bad_adr = ((wb_adr >> (ADR_WIDTH + 2)) != 32'd0) || (wb_adr[1:0] != 2'b00);
`else
   // Out-of-range and misaligned addresses simply alias into the SRAM.
   logic unused_adr;
   assign bad_adr    = 1'b0;
   assign unused_adr = ^{wb_adr[31:ADR_WIDTH+2], wb_adr[1:0]};
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         dat_r_q   <= '0;
         byte_en_q <= '0;
         rd_en_q   <= 1'b0;
         wr_en_q   <= 1'b0;
         ack_q     <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         dat_r_q   <= dat_r_d;
         byte_en_q <= byte_en_d;
         rd_en_q   <= rd_en_d;
         wr_en_q   <= wr_en_d;
         ack_q     <= ack_d;
         err_q     <= err_d;
      end
   end

   // Dropping wb_cyc mid-transfer abandons it once the current strobe has gone out.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req) state_d = bad_adr ? RESP : (wb_we ? WR_REQ : RD_REQ);
         RD_REQ:  state_d = wb_cyc ? RD_CAP : IDLE;
         RD_CAP:  state_d = wb_cyc ? RESP : IDLE;
         WR_REQ:  state_d = wb_cyc ? RESP : IDLE;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so every SRAM/bus signal leaves a flop.
   always_comb begin
      accept    = (state_q == IDLE) && req && !bad_adr;
      addr_d    = accept ? wb_adr[ADR_WIDTH+1:2] : addr_q;
      wdata_d   = (accept && wb_we) ? wb_dat_w : wdata_q;
      rd_en_d   = (state_d == RD_REQ);
      wr_en_d   = (state_d == WR_REQ);
      byte_en_d = (state_d == WR_REQ) ? wb_sel : '0;
      dat_r_d   = (state_q == RD_CAP && wb_cyc) ? i_read_data : dat_r_q;
      ack_d     = (state_d == RESP) && (state_q != IDLE);
      err_d     = (state_d == RESP) && (state_q == IDLE);
   end

   assign wb_dat_r     = dat_r_q;
   assign wb_ack       = ack_q;
   assign wb_err       = err_q;
   assign i_addr       = addr_q;
   assign i_write_data = wdata_q;
   assign i_byte_en    = byte_en_q;
   assign i_read_en    = rd_en_q;
   assign i_write_en   = wr_en_q;

endmodule

// File: tb/tb_clusterv_tile_sram_wb_bridge.sv
// Scoreboard bench for the tile SRAM Wishbone bridge with a one-cycle-latency SRAM model.
module tb_clusterv_tile_sram_wb_bridge;

   logic        clock;
   logic        reset;
   logic [31:0] wb_adr;
   logic [31:0] wb_dat_w;
   logic [31:0] wb_dat_r;
   logic        wb_cyc, wb_stb, wb_we;
   logic [3:0]  wb_sel;
   logic        wb_ack, wb_err;
   logic [7:0]  i_addr;
   logic [31:0] i_write_data;
   logic [31:0] i_read_data;
   logic [3:0]  i_byte_en;
   logic        i_read_en, i_write_en;

   int total = 0;
   int bad   = 0;

   typedef struct {
      bit          rd;
      logic [31:0] dat;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   logic [31:0] mem     [256];
   logic [31:0] ref_mem [256];
   logic [31:0] rdata;

   clusterv_tile_sram_wb_bridge dut (
      .clock        (clock),
      .reset        (reset),
      .wb_adr       (wb_adr),
      .wb_dat_w     (wb_dat_w),
      .wb_dat_r     (wb_dat_r),
      .wb_cyc       (wb_cyc),
      .wb_stb       (wb_stb),
      .wb_we        (wb_we),
      .wb_sel       (wb_sel),
      .wb_ack       (wb_ack),
      .wb_err       (wb_err),
      .i_addr       (i_addr),
      .i_write_data (i_write_data),
      .i_read_data  (i_read_data),
      .i_byte_en    (i_byte_en),
      .i_read_en    (i_read_en),
      .i_write_en   (i_write_en)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // SRAM macro: read data appears the cycle after the request.
   always @(posedge clock) begin
      if (i_write_en)
         for (int b = 0; b < 4; b++)
            if (i_byte_en[b]) mem[i_addr][8*b +: 8] <= i_write_data[8*b +: 8];
      if (i_read_en) rdata <= mem[i_addr];
   end
   assign i_read_data = rdata;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   always @(negedge clock) begin
      if (wb_ack) begin
         chk("ack_expected", {31'd0, sb.size() != 0}, 32'd1);
         if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            if (mon_e.rd) chk("sb_rd_data", wb_dat_r, mon_e.dat);
         end
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_bus();
      wb_cyc = 1'b0;
      wb_stb = 1'b0;
      wb_we  = 1'b0;
   endtask

   task automatic do_wr(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
      logic [7:0] w;
      exp_t e;
      w = adr[9:2];
      wb_adr = adr; wb_dat_w = dat; wb_sel = sel;
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1;
      for (int b = 0; b < 4; b++)
         if (sel[b]) ref_mem[w][8*b +: 8] = dat[8*b +: 8];
      e.rd = 1'b0; e.dat = '0;
      sb.push_back(e);
      step();
      chk("wr_c1_wen", {31'd0, i_write_en}, 32'd1);
      chk("wr_c1_ren", {31'd0, i_read_en}, 32'd0);
      chk("wr_c1_addr", {24'd0, i_addr}, {24'd0, w});
      chk("wr_c1_be", {28'd0, i_byte_en}, {28'd0, sel});
      chk("wr_c1_wdata", i_write_data, dat);
      chk("wr_c1_ack", {31'd0, wb_ack}, 32'd0);
      step();
      chk("wr_c2_ack", {31'd0, wb_ack}, 32'd1);
      chk("wr_c2_err", {31'd0, wb_err}, 32'd0);
      chk("wr_c2_wen", {31'd0, i_write_en}, 32'd0);
      idle_bus();
      step();
      chk("wr_c3_ack", {31'd0, wb_ack}, 32'd0);
   endtask

   task automatic do_rd(input logic [31:0] adr);
      logic [7:0] w;
      exp_t e;
      w = adr[9:2];
      wb_adr = adr; wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0;
      e.rd = 1'b1; e.dat = ref_mem[w];
      sb.push_back(e);
      step();
      chk("rd_c1_ren", {31'd0, i_read_en}, 32'd1);
      chk("rd_c1_wen", {31'd0, i_write_en}, 32'd0);
      chk("rd_c1_be", {28'd0, i_byte_en}, 32'd0);
      chk("rd_c1_addr", {24'd0, i_addr}, {24'd0, w});
      chk("rd_c1_ack", {31'd0, wb_ack}, 32'd0);
      step();
      chk("rd_c2_ren", {31'd0, i_read_en}, 32'd0);
      chk("rd_c2_ack", {31'd0, wb_ack}, 32'd0);
      step();
      chk("rd_c3_ack", {31'd0, wb_ack}, 32'd1);
      chk("rd_c3_data", wb_dat_r, ref_mem[w]);
      idle_bus();
      step();
      chk("rd_c4_ack", {31'd0, wb_ack}, 32'd0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_ack"}, {31'd0, wb_ack}, 32'd0);
      chk({tag, "_err"}, {31'd0, wb_err}, 32'd0);
      chk({tag, "_dat_r"}, wb_dat_r, 32'd0);
      chk({tag, "_ren"}, {31'd0, i_read_en}, 32'd0);
      chk({tag, "_wen"}, {31'd0, i_write_en}, 32'd0);
      chk({tag, "_be"}, {28'd0, i_byte_en}, 32'd0);
      chk({tag, "_addr"}, {24'd0, i_addr}, 32'd0);
      chk({tag, "_wdata"}, i_write_data, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      wb_adr = '0; wb_dat_w = '0; wb_sel = '0;
      idle_bus();
      repeat (3) step();
      chk_reset_outputs("rst");
      reset = 1'b0;
      step();

      // directed write / read / partial write
      do_wr(32'h10, 32'hDEADBEEF, 4'hF);
      do_rd(32'h10);
      do_wr(32'h10, 32'h000000AA, 4'h1);
      do_rd(32'h10);
      chk("partial_ref", ref_mem[4], 32'hDEADBEAA);

      // zero byte-select write is acked and changes nothing
      do_wr(32'h10, 32'h55555555, 4'h0);
      do_rd(32'h10);

      // abort in RD_CAP: no ack, bridge idle the next cycle
      wb_adr = 32'h10; wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0;
      step();
      step();
      idle_bus();
      step();
      chk("abort_ack", {31'd0, wb_ack}, 32'd0);
      chk("abort_ren", {31'd0, i_read_en}, 32'd0);
      do_wr(32'h20, 32'hCAFEF00D, 4'hF);

      // reset pulsed in RD_CAP
      wb_adr = 32'h10; wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0;
      step();
      step();
      reset = 1'b1;
      idle_bus();
      step();
      chk_reset_outputs("midrst");
      reset = 1'b0;
      step();
      do_rd(32'h10);

      // fill words 0..15, random partial updates, back-to-back reads
      for (int i = 0; i < 16; i++) do_wr(32'(i * 4), $urandom, 4'hF);
      for (int i = 0; i < 8; i++)
         do_wr(32'($urandom_range(0, 15) * 4), $urandom, 4'($urandom_range(0, 15)));
      for (int i = 0; i < 16; i++) do_rd(32'(i * 4));

`ifdef CLUSTERV_TILE_SRAM_BRIDGE_ERR_EN
      wb_adr = 32'h400; wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0;
      step();
      chk("err_c1_err", {31'd0, wb_err}, 32'd1);
      chk("err_c1_ack", {31'd0, wb_ack}, 32'd0);
      chk("err_c1_ren", {31'd0, i_read_en}, 32'd0);
      idle_bus();
      step();
      chk("err_c2_err", {31'd0, wb_err}, 32'd0);
      chk("err_c2_ack", {31'd0, wb_ack}, 32'd0);
      step();
      chk("err_c3_ack", {31'd0, wb_ack}, 32'd0);
`else
      // 0x400 aliases to word 0
      wb_adr = 32'h400; wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0;
      begin
         exp_t e;
         e.rd = 1'b1; e.dat = ref_mem[0];
         sb.push_back(e);
      end
      step();
      chk("alias_c1_ren", {31'd0, i_read_en}, 32'd1);
      chk("alias_c1_addr", {24'd0, i_addr}, 32'd0);
      step();
      chk("alias_c2_ack", {31'd0, wb_ack}, 32'd0);
      step();
      chk("alias_c3_ack", {31'd0, wb_ack}, 32'd1);
      chk("alias_c3_err", {31'd0, wb_err}, 32'd0);
      chk("alias_c3_data", wb_dat_r, ref_mem[0]);
      idle_bus();
      step();
`endif

      step();
      chk("sb_empty", sb.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/clusterv_tile_sram_wb_bridge.md
# clusterv_tile_sram_wb_bridge

Wishbone classic target that sits directly upstream of the tile SRAM wrapper and converts single bus transfers into the generic byte-enable SRAM initiator protocol. It registers every SRAM request, absorbs the macro's one-cycle read latency, and returns a registered single-cycle ack. One instance per tile, between the tile interconnect and the tile SRAM.

## Interface
- ADR_WIDTH, 8: SRAM word-address width (256 words).
- DAT_WIDTH, 32: data width; byte-enable width is DAT_WIDTH/8.
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- wb_adr  in  32  byte address; word index = wb_adr[ADR_WIDTH+1:2].
- wb_dat_w  in  DAT_WIDTH  write data.
- wb_dat_r  out  DAT_WIDTH  read data, registered.
- wb_cyc, wb_stb, wb_we  in  1  classic Wishbone qualifiers.
- wb_sel  in  DAT_WIDTH/8  byte selects.
- wb_ack  out  1  single-cycle ack pulse.
- wb_err  out  1  error pulse (tied 0 unless CLUSTERV_TILE_SRAM_BRIDGE_ERR_EN).
- i_addr  out  ADR_WIDTH  SRAM word address.
- i_write_data  out  DAT_WIDTH  SRAM write data.
- i_read_data  in  DAT_WIDTH  SRAM read data, valid the cycle after the request cycle.
- i_byte_en  out  DAT_WIDTH/8  SRAM byte write mask.
- i_read_en, i_write_en  out  1  SRAM request strobes, mutually exclusive.

## Operation
- FSM states: IDLE, RD_REQ, RD_CAP, WR_REQ, RESP.
- IDLE: on wb_cyc&wb_stb, latch address/data/sel; go RD_REQ (wb_we=0) or WR_REQ (wb_we=1).
- RD_REQ: i_read_en=1, i_byte_en=0; go RD_CAP.
- RD_CAP: capture i_read_data into wb_dat_r; go RESP.
- WR_REQ: i_write_en=1, i_byte_en=latched wb_sel, i_write_data=latched wb_dat_w; go RESP.
- RESP: wb_ack=1 for exactly one cycle; go IDLE. No new transfer accepted in RESP.
- i_addr holds last latched word address; all SRAM outputs are registered.
- wb_sel=0 write: still issued (no bytes change) and acked.
- wb_cyc deasserted in RD_REQ/RD_CAP/WR_REQ: transfer aborted, no ack, return IDLE after current SRAM strobe (write already issued still commits).
- wb_dat_r retains last read value until next read capture.

## Timing
- Reset: state IDLE; wb_ack=0, wb_err=0, wb_dat_r=0, i_read_en=0, i_write_en=0, i_byte_en=0, i_addr=0, i_write_data=0.
- Read: stb seen cycle 0; i_read_en cycle 1; data captured end of cycle 2; wb_ack cycle 3. Back-to-back reads: next stb sampled cycle 4, one transfer per 4 cycles.
- Write: stb cycle 0; i_write_en cycle 1; wb_ack cycle 2. Throughput one write per 3 cycles.
- Reset asserted mid-transfer: next cycle all outputs at reset values, no ack; in-flight SRAM write may or may not have committed.

## Configuration
- CLUSTERV_TILE_SRAM_BRIDGE_ERR_EN defined: in IDLE, if wb_adr bits above ADR_WIDTH+1 are nonzero or wb_adr[1:0]!=0, no SRAM strobe is issued; go RESP with wb_err=1, wb_ack=0 (error latency: err in cycle 1).
- Undefined: upper/low bits ignored, addresses alias into SRAM; wb_err tied 0.

## Structure
- Shared package clusterv_tile_sram_bridge_pkg: FSM state enum, default ADR_WIDTH/DAT_WIDTH constants.
- Single module; no sub-module is natural. SRAM side uses the codebase's generic byte-enable initiator port macro with prefix i_, ADR_WIDTH, DAT_WIDTH.

## Test plan
- Write 0xDEADBEEF, sel=4'hF to 0x10 -> i_write_en cycle 1, i_addr=0x04, i_byte_en=4'hF; wb_ack cycle 2 only.
- Read 0x10 after above (SRAM model) -> i_read_en cycle 1, wb_ack cycle 3, wb_dat_r=0xDEADBEEF.
- Write 0x000000AA sel=4'h1 to 0x10, read back -> 0xDEADBEAA.
- wb_cyc dropped in cycle 2 of a read -> no wb_ack, FSM IDLE in cycle 3, next write acks normally.
- reset pulsed in RD_CAP -> all outputs 0 next cycle, no ack; subsequent read completes in 4 cycles.
- ERR_EN build: read 0x400 -> no i_read_en, wb_err cycle 1, wb_ack never; non-ERR_EN build: same read aliases to word 0, acks cycle 3.
